// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/step defaults,
// the per-cycle action encoding and an address-alignment helper.
package fetch_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  // What the fetch stage does with its state this cycle (reset handled separately)
  typedef enum logic [2:0] {
    ACT_HOLD  = 3'd0,
    ACT_REDIR = 3'd1,
    ACT_STALL = 3'd2,
    ACT_ADV   = 3'd3
  } fetch_act_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage control inputs and decode-facing outputs. The perf counter
// signals are always present; they read zero unless FETCH_PERF_EN is defined.
interface fetch_if;
  import fetch_pkg::*;

  logic              stall;
  logic              halt;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] mem_addr_0;
  logic [ADDR_W-1:0] pc_out;
  logic              bubble_out;
  logic [31:0]       fetch_count;
  logic [31:0]       bubble_count;

  modport master (
    input  stall, halt, redirect, redirect_pc,
    output mem_addr_0, pc_out, bubble_out, fetch_count, bubble_count
  );

  modport slave (
    output stall, halt, redirect, redirect_pc,
    input  mem_addr_0, pc_out, bubble_out, fetch_count, bubble_count
  );

endinterface

// File: rtl/fetch_perf.sv
// Saturating valid-fetch and bubble counters for the fetch stage.
// Compiled only when FETCH_PERF_EN is defined.
`ifdef FETCH_PERF_EN
module fetch_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        bubble_inc_i,
  output logic [31:0] fetch_count_o,
  output logic [31:0] bubble_count_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Increment on request, stick at all-ones
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (fetch_inc_i && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (bubble_inc_i && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_count_o  = fetch_cnt_q;
  assign bubble_count_o = bubble_cnt_q;

endmodule
`endif

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues memory addresses and
// tags the returning word for decode. FETCH_PERF_EN adds fetch/bubble counters.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned       PC_STEP  = INSTR_BYTES
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              bubble_q, bubble_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  fetch_act_e        act_c;

  // Priority: halt > (live or pending) redirect > stall > advance
  always_comb begin
    act_c = ACT_ADV;
    if (bus.halt) begin
      act_c = ACT_HOLD;
    end else if (bus.redirect || pend_valid_q) begin
      act_c = ACT_REDIR;
    end else if (bus.stall) begin
      act_c = ACT_STALL;
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pc_out_d     = pc_out_q;
    bubble_d     = bubble_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    case (act_c)
      ACT_HOLD: begin
        // A redirect seen while frozen is parked; the latest one wins
        if (bus.redirect) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = word_align(bus.redirect_pc);
        end
      end
      ACT_REDIR: begin
        fetch_pc_d   = bus.redirect ? word_align(bus.redirect_pc) : pend_pc_q;
        pc_out_d     = fetch_pc_q;
        bubble_d     = 1'b1;
        pend_valid_d = 1'b0;
      end
      ACT_STALL: begin
      end
      ACT_ADV: begin
        pc_out_d   = fetch_pc_q;
        bubble_d   = 1'b0;
        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      pc_out_q     <= '0;
      bubble_q     <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pc_out_q     <= pc_out_d;
      bubble_q     <= bubble_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign bus.mem_addr_0 = word_align(fetch_pc_q);
  assign bus.pc_out     = pc_out_q;
  assign bus.bubble_out = bubble_q;

`ifdef FETCH_PERF_EN
  logic fetch_inc;
  logic bubble_inc;

  assign fetch_inc  = (act_c == ACT_ADV);
  assign bubble_inc = (act_c == ACT_REDIR);

  fetch_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_inc_i    (fetch_inc),
    .bubble_inc_i   (bubble_inc),
    .fetch_count_o  (bus.fetch_count),
    .bubble_count_o (bus.bubble_count)
  );
`else
  assign bus.fetch_count  = 32'd0;
  assign bus.bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: directed stimulus pushes the expected visible
// state, negedge monitors pop and compare against two DUT instances.
module tb_fetch;
  import fetch_pkg::*;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic        bub;
    logic [31:0] fc;
    logic [31:0] bc;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_if bus_w ();

  fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_w (
    .clk (clk),
    .rst (rst_w),
    .bus (bus_w.master)
  );

  exp_t q[$];
  exp_t qw[$];
  int errors = 0;
  int checks = 0;

  int unsigned m_fc;
  int unsigned m_bc;
  bit          m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.tag, ".addr"}, bus.mem_addr_0, e.addr);
      chk({e.tag, ".pc"}, bus.pc_out, e.pc);
      chk({e.tag, ".bub"}, 32'(bus.bubble_out), 32'(e.bub));
      chk({e.tag, ".fcnt"}, bus.fetch_count, e.fc);
      chk({e.tag, ".bcnt"}, bus.bubble_count, e.bc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (qw.size() != 0) begin
      e = qw.pop_front();
      chk({e.tag, ".addr"}, bus_w.mem_addr_0, e.addr);
      chk({e.tag, ".pc"}, bus_w.pc_out, e.pc);
      chk({e.tag, ".bub"}, 32'(bus_w.bubble_out), 32'(e.bub));
      chk({e.tag, ".fcnt"}, bus_w.fetch_count, e.fc);
      chk({e.tag, ".bcnt"}, bus_w.bubble_count, e.bc);
    end
  end

  // Push the currently visible state, drive next-cycle inputs, advance one clock
  task automatic step(input string tag, input logic r, input logic s, input logic h,
                      input logic rd, input logic [31:0] rpc,
                      input logic [31:0] ea, input logic [31:0] ep, input logic eb);
    exp_t e;
    rst             = r;
    bus.stall       = s;
    bus.halt        = h;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    e.addr = ea;
    e.pc   = ep;
    e.bub  = eb;
    e.fc   = PERF ? m_fc : 32'd0;
    e.bc   = PERF ? m_bc : 32'd0;
    e.tag  = tag;
    q.push_back(e);
    if (r) begin
      m_fc = 0; m_bc = 0; m_pend = 1'b0;
    end else if (h) begin
      if (rd) m_pend = 1'b1;
    end else if (rd || m_pend) begin
      m_bc++; m_pend = 1'b0;
    end else if (!s) begin
      m_fc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wstep(input string tag, input logic r, input logic [31:0] ea,
                       input logic [31:0] ep, input logic eb, input logic [31:0] efc);
    exp_t e;
    rst_w  = r;
    e.addr = ea;
    e.pc   = ep;
    e.bub  = eb;
    e.fc   = PERF ? efc : 32'd0;
    e.bc   = 32'd0;
    e.tag  = tag;
    qw.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rst_w = 1'b1;
    bus.stall = 1'b0; bus.halt = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus_w.stall = 1'b0; bus_w.halt = 1'b0; bus_w.redirect = 1'b0; bus_w.redirect_pc = '0;
    m_fc = 0; m_bc = 0; m_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //    tag        rst s  h  rd rpc           addr          pc            bub
    step("reset",    1, 0, 0, 0, 32'h0,   32'h0,   32'h0,   1);
    step("seq0",     0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   1);
    step("seq4",     0, 0, 0, 0, 32'h0,   32'h4,   32'h0,   0);
    step("seq8",     0, 0, 0, 0, 32'h0,   32'h8,   32'h4,   0);
    step("seqC",     0, 0, 0, 0, 32'h0,   32'hC,   32'h8,   0);
    step("stall0",   0, 1, 0, 0, 32'h0,   32'h10,  32'hC,   0);
    step("stall1",   0, 1, 0, 0, 32'h0,   32'h10,  32'hC,   0);
    step("stall2",   0, 1, 0, 0, 32'h0,   32'h10,  32'hC,   0);
    step("stall3",   0, 0, 0, 0, 32'h0,   32'h10,  32'hC,   0);
    step("resume",   0, 0, 0, 0, 32'h0,   32'h14,  32'h10,  0);
    step("seq18",    0, 0, 0, 0, 32'h0,   32'h18,  32'h14,  0);
    step("seq1C",    0, 0, 0, 0, 32'h0,   32'h1C,  32'h18,  0);
    step("redir",    0, 0, 0, 1, 32'h200, 32'h20,  32'h1C,  0);
    step("redir+1",  0, 0, 0, 0, 32'h0,   32'h200, 32'h20,  1);
    step("halt0",    0, 0, 1, 1, 32'h280, 32'h204, 32'h200, 0);
    step("halt1",    0, 0, 1, 1, 32'h300, 32'h204, 32'h200, 0);
    step("halt2",    0, 0, 1, 0, 32'h0,   32'h204, 32'h200, 0);
    step("halt3",    0, 0, 1, 0, 32'h0,   32'h204, 32'h200, 0);
    step("unhalt",   0, 0, 0, 0, 32'h0,   32'h204, 32'h200, 0);
    step("pend",     0, 0, 0, 0, 32'h0,   32'h300, 32'h204, 1);
    step("rdstall",  0, 1, 0, 1, 32'h401, 32'h304, 32'h300, 0);
    step("rdst+1",   0, 1, 0, 0, 32'h0,   32'h400, 32'h304, 1);
    step("rdst+2",   0, 0, 0, 0, 32'h0,   32'h400, 32'h304, 1);
    step("rstprio",  1, 0, 1, 1, 32'h500, 32'h404, 32'h400, 0);
    step("rsthalt",  0, 0, 1, 0, 32'h0,   32'h0,   32'h0,   1);
    step("nopend",   0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   1);
    step("seq4b",    0, 0, 0, 0, 32'h0,   32'h4,   32'h0,   0);
    step("hpend",    0, 0, 1, 1, 32'h600, 32'h8,   32'h4,   0);
    step("livewin",  0, 0, 0, 1, 32'h700, 32'h8,   32'h4,   0);
    step("live+1",   0, 0, 0, 0, 32'h0,   32'h700, 32'h8,   1);
    step("live+2",   0, 0, 0, 0, 32'h0,   32'h704, 32'h700, 0);
    // Wrap instance: three sequential fetches from FFFF_FFF8
    wstep("wrap0",   0, 32'hFFFF_FFF8, 32'h0,         1, 32'd0);
    wstep("wrap1",   0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 0, 32'd1);
    wstep("wrap2",   0, 32'h0000_0000, 32'hFFFF_FFFC, 0, 32'd2);
    wstep("wrap3",   0, 32'h0000_0004, 32'h0000_0000, 0, 32'd3);
    @(negedge clk);
    chk("drain", 32'(q.size() + qw.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
